// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//
// Adds two WORDS x 16-bit operands by streaming 16-bit slices, least-significant
// slice first, through one external 16-bit adder. The carry out of each slice is
// held in a register and fed back as the carry into the next slice, so a single
// narrow adder covers 32/64-bit (or wider) additions at one slice per cycle.
//
// Operation: IDLE -> (start) -> RUN for WORDS cycles -> DONE for one cycle -> IDLE.
// Throughput is one operation per WORDS+2 cycles.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous, active-high reset
//   start     request, sampled only while ready=1
//   a_in      operand A (16*WORDS bits), captured on the accepted start
//   b_in      operand B (16*WORDS bits), captured on the accepted start
//   cin       carry into slice 0, captured on the accepted start
//   ready     high in IDLE only
//   busy      high in RUN only
//   done      one-cycle completion pulse (DONE state)
//   result    sum of the last completed operation
//   cout      carry out of the top slice of the last completed operation
//   add_a     slice of A to the external adder (0 outside RUN)
//   add_b     slice of B to the external adder (0 outside RUN)
//   add_cin   inter-slice carry to the external adder (0 outside RUN)
//   add_sum   combinational sum from the external adder
//   add_cout  combinational carry out from the external adder

module multiword_add_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*WORDS-1:0]  a_in,
    input  logic [16*WORDS-1:0]  b_in,
    input  logic                 cin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [16*WORDS-1:0]  result,
    output logic                 cout,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic                 add_cin,
    input  logic [15:0]          add_sum,
    input  logic                 add_cout
);

    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned OPW  = 16 * WORDS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [OPW-1:0]    a_q;
    logic [OPW-1:0]    b_q;
    logic [OPW-1:0]    shadow_q;
    logic [OPW-1:0]    result_q;
    logic              cout_q;

    logic              accept;
    logic              last_slice;
    logic [15:0]       a_slice;
    logic [15:0]       b_slice;
    logic [OPW-1:0]    shadow_d;
    logic [OPW-1:0]    result_d;

    assign accept     = (state_q == StIdle) && start;
    assign last_slice = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_slice) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
            end
            StRun: begin
                busy    = 1'b1;
                add_a   = a_slice;
                add_b   = b_slice;
                add_cin = carry_q;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice select and slice write-back
    // ------------------------------------------------------------------
    // Explicit compare-and-select keeps idx width independent of the
    // part-select base arithmetic.
    always_comb begin
        a_slice  = '0;
        b_slice  = '0;
        shadow_d = shadow_q;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_slice              = a_q[16*i +: 16];
                b_slice              = b_q[16*i +: 16];
                shadow_d[16*i +: 16] = add_sum;
            end
        end
    end

    // The top slice comes straight from the adder; lower slices were
    // collected in the shadow register on earlier RUN edges.
    always_comb begin
        result_d                      = shadow_q;
        result_d[16*(WORDS-1) +: 16]  = add_sum;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            shadow_q <= shadow_d;
            carry_q  <= add_cout;
            if (last_slice) begin
                // idx parks at WORDS-1 until the next accepted start.
                result_q <= result_d;
                cout_q   <= add_cout;
            end else begin
                idx_q <= idx_q + IDXW'(1);
            end
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- WORDS=4 instance ----------------
    logic        start = 1'b0;
    logic [63:0] a_in  = '0;
    logic [63:0] b_in  = '0;
    logic        cin   = 1'b0;
    logic        ready, busy, done, cout;
    logic [63:0] result;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    // 16-bit adder model feeding the sequencer
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    multiword_add_sequencer #(.WORDS(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // ---------------- WORDS=1 instance ----------------
    logic        s1_start = 1'b0;
    logic [15:0] s1_a_in  = '0;
    logic [15:0] s1_b_in  = '0;
    logic        s1_cin   = 1'b0;
    logic        s1_ready, s1_busy, s1_done, s1_cout;
    logic [15:0] s1_result;
    logic [15:0] s1_add_a, s1_add_b, s1_add_sum;
    logic        s1_add_cin, s1_add_cout;

    always_comb {s1_add_cout, s1_add_sum} =
        {1'b0, s1_add_a} + {1'b0, s1_add_b} + {16'd0, s1_add_cin};

    multiword_add_sequencer #(.WORDS(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (s1_start),
        .a_in     (s1_a_in),
        .b_in     (s1_b_in),
        .cin      (s1_cin),
        .ready    (s1_ready),
        .busy     (s1_busy),
        .done     (s1_done),
        .result   (s1_result),
        .cout     (s1_cout),
        .add_a    (s1_add_a),
        .add_b    (s1_add_b),
        .add_cin  (s1_add_cin),
        .add_sum  (s1_add_sum),
        .add_cout (s1_add_cout)
    );

    // Observations of one WORDS=4 operation, cycle k=1 is the cycle after E0
    int         done_cnt, busy_cnt, ready_cnt, done_at;
    logic [3:0] cin_seq;

    task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input int inject);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 64'hDEAD_BEEF_DEAD_BEEF;
        b_in  = 64'hDEAD_BEEF_DEAD_BEEF;
        cin   = 1'b1;
        done_cnt  = 0;
        busy_cnt  = 0;
        ready_cnt = 0;
        done_at   = 0;
        cin_seq   = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (ready && k <= 5) ready_cnt++;
            if (k <= 4) cin_seq[k-1] = add_cin;
            if (k == inject) begin
                start = 1'b1;
                a_in  = 64'h0000_0000_0000_AAAA;
                b_in  = 64'h0000_0000_0000_5555;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1_cnt, d1_first, d1_second;
        logic [15:0] r1_first;
        logic        c1_first;

        // Reset values
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_add_a", add_a, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: carry across slice boundary, timing
        run4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0);
        chk("t1_result", result, 64'h0000_0000_0001_0000);
        chk("t1_cout", cout, 0);
        chk("t1_done_at", done_at, 5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_cnt", busy_cnt, 4);
        chk("t1_idle_add_a", add_a, 0);
        chk("t1_idle_add_cin", add_cin, 0);

        // 2: carry ripples through all slices
        run4(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
        chk("t2_result", result, 64'h0);
        chk("t2_cout", cout, 1);

        // 3: mixed pattern, inter-slice carries 0,1,1,1
        run4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 0);
        chk("t3_result", result, 64'h2222_2222_2222_2211);
        chk("t3_cout", cout, 0);
        chk("t3_cin_seq", cin_seq, 4'b1110);

        // 4: start during RUN is ignored
        run4(64'h5, 64'h7, 1'b0, 2);
        chk("t4_result", result, 64'hC);
        chk("t4_ready_cnt", ready_cnt, 0);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_ready_after", ready, 1);

        // 5: async reset in the 2nd RUN cycle
        @(negedge clk);
        start = 1'b1;
        a_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        b_in  = 64'h1;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_ready", ready, 1);
        chk("t5_result", result, 0);
        chk("t5_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("t5_no_done", done_cnt, 0);
        run4(64'h1, 64'h1, 1'b0, 0);
        chk("t5_fresh_result", result, 64'h2);
        chk("t5_fresh_done_at", done_at, 5);

        // 6: WORDS=1, single RUN cycle, back-to-back starts every 3 cycles
        @(negedge clk);
        s1_start = 1'b1;
        s1_a_in  = 16'hFFFF;
        s1_b_in  = 16'h0001;
        s1_cin   = 1'b0;
        d1_cnt    = 0;
        d1_first  = 0;
        d1_second = 0;
        r1_first  = '1;
        c1_first  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (s1_done) begin
                d1_cnt++;
                if (d1_cnt == 1) begin
                    d1_first = k;
                    r1_first = s1_result;
                    c1_first = s1_cout;
                end
                if (d1_cnt == 2) d1_second = k;
            end
        end
        s1_start = 1'b0;
        chk("t6_result", r1_first, 16'h0000);
        chk("t6_cout", c1_first, 1);
        chk("t6_done_first", d1_first, 2);
        chk("t6_done_gap", d1_second - d1_first, 3);
        chk("t6_done_cnt", d1_cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
